// File: rtl/des_pkg.sv
// des_pkg: DES permutation/substitution tables, FSM states and bit-permutation helpers.
// Table entries use DES 1-based numbering; DES bit n lives at vector bit [W-n].
package des_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
   localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                 10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
   localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                               12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                               24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
   localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
   localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   // each S-box row is indexed by {b1,b6,b2..b5} of its 6-bit input
   localparam logic [3:0] SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
   function automatic logic [63:0] ip64(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
      return y;
   endfunction
   function automatic logic [63:0] fp64(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
      return y;
   endfunction
   function automatic logic [55:0] pc1_56(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
      return y;
   endfunction
   function automatic logic [47:0] pc2_48(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
      return y;
   endfunction
   function automatic logic [47:0] e48(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[47 - i] = x[32 - E_T[i]];
      return y;
   endfunction
   function automatic logic [31:0] p32(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[31 - i] = x[32 - P_T[i]];
      return y;
   endfunction
   function automatic logic [31:0] sbox32(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0] b;
      for (int i = 0; i < 8; i++) begin
         b = x[47 - 6 * i -: 6];
         y[31 - 4 * i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
      end
      return y;
   endfunction
   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction
   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      return (x >> n) | (x << (28 - n));
   endfunction
endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES round including its key-schedule rotation.
module des_round
   import des_pkg::*;
(
   input  logic [31:0] l,
   input  logic [31:0] r,
   input  logic [27:0] c,
   input  logic [27:0] d,
   input  logic [4:0]  idx,
   input  logic        decrypt,
   output logic [31:0] l_next,
   output logic [31:0] r_next,
   output logic [27:0] c_next,
   output logic [27:0] d_next
);
   int sh;
   logic [47:0] k;
   logic [31:0] f;
   // decrypt walks the schedule backwards from C16/D16 == C0/D0
   always_comb begin
      sh = decrypt ? (idx == 5'd1 ? 0 : SHIFT[18 - int'(idx)]) : SHIFT[int'(idx)];
      c_next = decrypt ? rotr28(c, sh) : rotl28(c, sh);
      d_next = decrypt ? rotr28(d, sh) : rotl28(d, sh);
   end
   assign k = pc2_48({c_next, d_next});
   feistel_function u_f (.r(r), .k(k), .f(f));
   assign l_next = r;
   assign r_next = l ^ f;
endmodule

// File: rtl/feistel_function.sv
// feistel_function: DES f(R,K) = P(S(E(R) xor K)).
module feistel_function
   import des_pkg::*;
(
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] f
);
   assign f = p32(sbox32(e48(r) ^ k));
endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES encrypt/decrypt, ROUNDS_PER_CYCLE rounds per clock,
// with valid/ready handshakes on input and output.
module des_round_engine
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_decrypt,
   input  logic [63:0] i_key,
   input  logic [63:0] i_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [63:0] o_data,
   output logic        o_busy
);
   localparam int RPC = ROUNDS_PER_CYCLE;
   localparam int STEPS = 16 / RPC;
   localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
   if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
      $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end
   state_t state, state_n;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [CW-1:0] cnt;
   logic dec, last;
   logic [RPC:0][31:0] lc, rc;
   logic [RPC:0][27:0] cc, dc;
   assign lc[0] = l;
   assign rc[0] = r;
   assign cc[0] = c;
   assign dc[0] = d;
   for (genvar g = 0; g < RPC; g++) begin : g_rnd
      des_round u_rnd (
         .l(lc[g]), .r(rc[g]), .c(cc[g]), .d(dc[g]),
         .idx(5'(int'(cnt) * RPC + g + 1)), .decrypt(dec),
         .l_next(lc[g+1]), .r_next(rc[g+1]), .c_next(cc[g+1]), .d_next(dc[g+1])
      );
   end
   assign last = cnt == CW'(STEPS - 1);
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = (state == IDLE && i_valid) ? RUN :
                (state == RUN && last)     ? DONE :
                (state == DONE && i_ready) ? IDLE : state;
   assign o_ready = state == IDLE;
   assign o_valid = state == DONE;
   assign o_busy = state != IDLE;
   // the output swap R16||L16 is folded into the final write
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         l <= '0;
         r <= '0;
         c <= '0;
         d <= '0;
         cnt <= '0;
         dec <= 1'b0;
         o_data <= '0;
      end else if (state == IDLE && i_valid) begin
         {l, r} <= ip64(i_data);
         {c, d} <= pc1_56(i_key);
         dec <= i_decrypt;
         cnt <= '0;
      end else if (state == RUN) begin
         l <= lc[RPC];
         r <= rc[RPC];
         c <= cc[RPC];
         d <= dc[RPC];
         cnt <= cnt + 1'b1;
         if (last) o_data <= fp64({rc[RPC], lc[RPC]});
      end
endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed known-answer, backpressure, abort and round-trip checks
// on five engines (1,2,4,8,16 rounds per clock) driven in lockstep.
module tb_des_round_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid = 1'b0, i_ready = 1'b0, i_decrypt = 1'b0;
   logic [63:0] i_key = '0, i_data = '0;
   logic [4:0] ordy, ov, obsy;
   logic [63:0] od [5];
   int tests = 0, fails = 0;
   logic [63:0] kat_key [5] = '{64'h133457799BBCDFF1, 64'h0, 64'h0E329232EA6D0D73,
                                64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF};
   logic [63:0] kat_pt [5] = '{64'h0123456789ABCDEF, 64'h0, 64'h8787878787878787,
                               64'h4E6F772069732074, 64'hFFFFFFFFFFFFFFFF};
   logic [63:0] kat_ct [5] = '{64'h85E813540F0AB405, 64'h8CA64DE9C1B123A7, 64'h0,
                               64'h3FA40E8A984D4815, 64'h7359B2163E4EDC58};
   always #5 clk = ~clk;
   for (genvar g = 0; g < 5; g++) begin : g_dut
      des_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) dut (
         .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(ordy[g]),
         .i_decrypt(i_decrypt), .i_key(i_key), .i_data(i_data), .o_valid(ov[g]),
         .i_ready(i_ready), .o_data(od[g]), .o_busy(obsy[g])
      );
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic start_block(input logic [63:0] key, input logic [63:0] data, input logic dec);
      @(negedge clk);
      check("ready_before_accept", 64'(ordy), 64'h1f);
      i_valid = 1'b1;
      i_key = key;
      i_data = data;
      i_decrypt = dec;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_key = ~key;
      i_data = ~data;
      i_decrypt = ~dec;
      check("busy_after_accept", 64'(obsy), 64'h1f);
   endtask
   task automatic wait_done(output logic [4:0][63:0] res);
      int lat [5];
      int n;
      n = 0;
      for (int g = 0; g < 5; g++) lat[g] = 0;
      while (ov != 5'h1f && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         for (int g = 0; g < 5; g++) if (ov[g] && lat[g] == 0) lat[g] = n;
      end
      for (int g = 0; g < 5; g++) begin
         check($sformatf("latency_r%0d", 1 << g), 64'(lat[g]), 64'(16 >> g));
         res[g] = od[g];
      end
   endtask
   task automatic release_block();
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
      check("valid_drop_after_take", 64'(ov), 64'h0);
      check("ready_after_take", 64'(ordy), 64'h1f);
   endtask
   task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                            output logic [4:0][63:0] res);
      start_block(key, data, dec);
      wait_done(res);
      release_block();
   endtask
   initial begin
      logic [4:0][63:0] res, res2;
      logic [63:0] k, p;
      int v;
      logic m;
      #12;
      check("reset_ready", 64'(ordy), 64'h1f);
      check("reset_valid", 64'(ov), 64'h0);
      check("reset_busy", 64'(obsy), 64'h0);
      for (int g = 0; g < 5; g++) check("reset_data", od[g], 64'h0);
      @(negedge clk);
      rst = 1'b0;
      run_block(kat_key[0], kat_pt[0], 1'b0, res);
      for (int g = 0; g < 5; g++) check($sformatf("kat_enc_r%0d", 1 << g), res[g], kat_ct[0]);
      run_block(kat_key[0], kat_ct[0], 1'b1, res);
      for (int g = 0; g < 5; g++) check($sformatf("kat_dec_r%0d", 1 << g), res[g], kat_pt[0]);
      run_block(kat_key[1], kat_pt[1], 1'b0, res);
      for (int g = 0; g < 5; g++) check($sformatf("kat_zero_r%0d", 1 << g), res[g], kat_ct[1]);
      start_block(kat_key[2], kat_pt[2], 1'b0);
      wait_done(res);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         i_valid = 1'b1;
         i_key = {$urandom, $urandom};
         i_data = {$urandom, $urandom};
         i_decrypt = c[0];
         @(posedge clk);
         #1;
         check("bp_valid", 64'(ov), 64'h1f);
         check("bp_ready", 64'(ordy), 64'h0);
         for (int g = 0; g < 5; g++) check("bp_data", od[g], kat_ct[2]);
      end
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_take_valid", 64'(ov), 64'h0);
      check("bp_take_ready", 64'(ordy), 64'h1f);
      check("bp_take_not_accepted", 64'(obsy), 64'h0);
      for (int g = 0; g < 5; g++) check("bp_data_held", od[g], kat_ct[2]);
      @(negedge clk);
      i_valid = 1'b0;
      i_ready = 1'b0;
      start_block(kat_key[0], kat_pt[0], 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("abort_r1_running", 64'(ov[0]), 64'h0);
      #2;
      rst = 1'b1;
      #1;
      check("abort_valid", 64'(ov), 64'h0);
      check("abort_busy", 64'(obsy), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready", 64'(ordy), 64'h1f);
      check("abort_data_cleared", od[0], 64'h0);
      run_block(kat_key[0], kat_pt[0], 1'b0, res);
      for (int g = 0; g < 5; g++) check($sformatf("post_abort_r%0d", 1 << g), res[g], kat_ct[0]);
      for (int t = 0; t < 4; t++) begin
         v = $urandom_range(0, 4);
         m = t[0];
         run_block(kat_key[v], m ? kat_ct[v] : kat_pt[v], m, res);
         for (int g = 0; g < 5; g++)
            check($sformatf("b2b_%0d_vec%0d_dec%0d_r%0d", t, v, m, 1 << g), res[g], m ? kat_pt[v] : kat_ct[v]);
      end
      for (int t = 0; t < 2; t++) begin
         k = {$urandom, $urandom};
         p = {$urandom, $urandom};
         run_block(k, p, 1'b0, res);
         run_block(k, res[0], 1'b1, res2);
         for (int g = 0; g < 5; g++) check($sformatf("roundtrip_%0d_r%0d", t, 1 << g), res2[g], p);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
